// File: rtl/aes_cbc_if.sv
// Valid/ready block streams between the CBC controller and its producer/consumer.
// The controller takes the slave side; the environment takes the master side.
interface aes_cbc_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_cbc_ctrl.sv
// ECB/CBC chaining front-end for aes_core_gen: one block in flight, pulses the
// core's start, waits for done (with timeout) and presents the result downstream.
module aes_cbc_ctrl #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_load,
  input  logic          cfg_enc_dec,
  input  logic          cfg_chain_en,
  input  logic [1:0]    cfg_mode,
  input  logic [255:0]  cfg_key,
  input  logic [127:0]  iv,
  aes_cbc_ctrl_if.slave strm,
  output logic          busy,
  output logic          err,
  output logic          core_start,
  output logic          core_enc_dec,
  output logic [1:0]    core_mode,
  output logic [255:0]  core_key,
  output logic [127:0]  core_data_in,
  input  logic [127:0]  core_data_out,
  input  logic          core_done
);

  localparam int SCW = $clog2(START_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]     state;
  logic [SCW-1:0] start_cnt;
  logic [TCW-1:0] wait_cnt;
  logic           chain_en;
  logic [127:0]   chain;
  logic [127:0]   next_chain;
  logic [127:0]   out_data_q;
  logic           accept;
  logic           done_ok;

  // Outputs decode straight from state, so they fall the instant reset_n asserts.
  assign busy          = (state != S_IDLE);
  assign core_start    = (state == S_START);
  assign strm.in_ready = reset_n && (state == S_IDLE) && !cfg_load;
  assign strm.out_valid = (state == S_OUT);
  assign strm.out_data  = out_data_q;

  assign accept  = strm.in_valid && strm.in_ready;
  // The first WAIT cycle may still see the previous block's done level.
  assign done_ok = core_done && (wait_cnt != '0);

  // NOTE: every register here uses <= so all flops update from pre-edge values;
  // the 128/256-bit data registers are reset too because their reset value is visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      start_cnt    <= '0;
      wait_cnt     <= '0;
      err          <= 1'b0;
      core_enc_dec <= 1'b0;
      core_mode    <= '0;
      core_key     <= '0;
      chain_en     <= 1'b0;
      chain        <= '0;
      next_chain   <= '0;
      core_data_in <= '0;
      out_data_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            core_enc_dec <= cfg_enc_dec;
            chain_en     <= cfg_chain_en;
            core_mode    <= cfg_mode;
            core_key     <= cfg_key;
            chain        <= iv;
            err          <= 1'b0;
          end else if (accept) begin
            core_data_in <= (chain_en && !core_enc_dec) ? (strm.in_data ^ chain) : strm.in_data;
            next_chain   <= strm.in_data;
            start_cnt    <= '0;
            state        <= S_START;
          end
        end
        S_START: begin
          if (start_cnt == SCW'(START_CYCLES - 1)) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            start_cnt <= start_cnt + SCW'(1);
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + TCW'(1);
          if (done_ok) begin
            out_data_q <= (chain_en && core_enc_dec) ? (core_data_out ^ chain) : core_data_out;
            if (chain_en) chain <= core_enc_dec ? next_chain : core_data_out;
            state <= S_OUT;
          end else if (wait_cnt == TCW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_OUT: begin
          if (strm.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Self-checking bench for aes_cbc_ctrl: behavioural AES core stand-in, CBC/ECB
// message-level reference model, known-answer vectors plus randomized messages.
module tb_aes_cbc_ctrl;
  localparam int SC = 2;
  localparam int TO = 16;

  localparam logic [255:0] KEY    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] IV     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT_ECB = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] CT1    = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CT2    = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] SCRAM  = 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         cfg_load = 1'b0, cfg_enc_dec = 1'b0, cfg_chain_en = 1'b0;
  logic [1:0]   cfg_mode = '0;
  logic [255:0] cfg_key = '0;
  logic [127:0] iv = '0;
  logic         busy, err, core_start, core_enc_dec;
  logic [1:0]   core_mode;
  logic [255:0] core_key;
  logic [127:0] core_data_in;
  logic [127:0] core_data_out = '0;
  logic         core_done = 1'b0;

  aes_cbc_ctrl_if strm();

  aes_cbc_ctrl #(.START_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_load(cfg_load), .cfg_enc_dec(cfg_enc_dec), .cfg_chain_en(cfg_chain_en),
    .cfg_mode(cfg_mode), .cfg_key(cfg_key), .iv(iv),
    .strm(strm),
    .busy(busy), .err(err), .core_start(core_start), .core_enc_dec(core_enc_dec),
    .core_mode(core_mode), .core_key(core_key), .core_data_in(core_data_in),
    .core_data_out(core_data_out), .core_done(core_done)
  );

  // Block cipher stand-in: known AES vectors by table, otherwise an invertible scramble.
  logic [127:0] enc_tab [logic [127:0]];
  logic [127:0] dec_tab [logic [127:0]];

  function automatic logic [127:0] ref_enc(input logic [127:0] x, input logic [255:0] k);
    if (enc_tab.exists(x)) return enc_tab[x];
    return {x[63:0], x[127:64]} ^ k[255:128] ^ SCRAM;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] y, input logic [255:0] k);
    logic [127:0] z;
    if (dec_tab.exists(y)) return dec_tab[y];
    z = y ^ k[255:128] ^ SCRAM;
    return {z[63:0], z[127:64]};
  endfunction

  // Core model: done stays stale for the first cycle after start falls, then
  // rises core_lat cycles later (never when core_hang is set).
  int           core_lat = 3;
  bit           core_hang = 1'b0;
  logic         start_d = 1'b0, pend = 1'b0, cap_enc = 1'b0;
  logic [1:0]   cap_mode = '0;
  logic [255:0] cap_key = '0;
  logic [127:0] cap_in = '0;
  int           cnt = 0;
  int           din_bad = 0;

  always @(posedge clk) begin
    start_d <= core_start;
    if (core_start) begin
      cap_in   <= core_data_in;
      cap_enc  <= core_enc_dec;
      cap_mode <= core_mode;
      cap_key  <= core_key;
      pend     <= 1'b0;
    end else if (start_d) begin
      core_done <= 1'b0;
      cnt       <= core_lat;
      pend      <= 1'b1;
    end else if (pend) begin
      if (busy && core_data_in !== cap_in) din_bad <= din_bad + 1;
      if (cnt <= 1) begin
        pend <= 1'b0;
        if (!core_hang) begin
          core_done     <= 1'b1;
          core_data_out <= cap_enc ? ref_dec(cap_in, cap_key) : ref_enc(cap_in, cap_key);
        end
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  int run_cur = 0, last_run = 0;
  always @(negedge clk) begin
    if (core_start) run_cur <= run_cur + 1;
    else if (run_cur != 0) begin
      last_run <= run_cur;
      run_cur  <= 0;
    end
  end

  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Message-level reference state.
  bit           m_dec = 1'b0, m_cbc = 1'b0;
  logic [1:0]   m_mode = '0;
  logic [255:0] m_key = '0;
  logic [127:0] m_chain = '0;

  task automatic load_cfg(input bit ed, input bit ce, input logic [1:0] md,
                          input logic [255:0] k, input logic [127:0] v);
    @(negedge clk);
    cfg_enc_dec = ed; cfg_chain_en = ce; cfg_mode = md; cfg_key = k; iv = v;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    m_dec = ed; m_cbc = ce; m_mode = md; m_key = k; m_chain = v;
    check("cfg_err_clear", 256'(err), 256'(0));
  endtask

  task automatic run_block(input logic [127:0] din, input int hold, input bit poke,
                           output logic [127:0] got);
    logic [127:0] exp;
    int cyc, bad0;
    if (!m_cbc) exp = m_dec ? ref_dec(din, m_key) : ref_enc(din, m_key);
    else if (!m_dec) begin exp = ref_enc(din ^ m_chain, m_key); m_chain = exp; end
    else begin exp = ref_dec(din, m_key) ^ m_chain; m_chain = din; end
    got  = '0;
    bad0 = din_bad;
    @(negedge clk);
    strm.in_valid = 1'b1;
    strm.in_data  = din;
    cyc = 0;
    while (!strm.in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    if (!strm.in_ready) begin
      check("in_ready_wait", 256'(strm.in_ready), 256'(1));
      strm.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    cyc = 0;
    do begin @(negedge clk); strm.in_valid = 1'b0; cyc++; end
    while (!strm.out_valid && cyc < 300);
    check("latency", 256'(cyc - 1), 256'(SC + 2 + core_lat));
    if (!strm.out_valid) return;
    got = strm.out_data;
    check("out_data", 256'(got), 256'(exp));
    check("start_len", 256'(last_run), 256'(SC));
    check("core_key", core_key, m_key);
    check("core_cfg", 256'({cap_enc, cap_mode}), 256'({m_dec, m_mode}));
    check("din_stable", 256'(din_bad - bad0), 256'(0));
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 3) begin
        cfg_enc_dec = ~m_dec; cfg_chain_en = ~m_cbc; cfg_key = ~m_key; iv = ~m_chain;
        cfg_load = 1'b1;
      end
      @(negedge clk);
      cfg_load = 1'b0;
      check("hold_valid", 256'(strm.out_valid), 256'(1));
      check("hold_data", 256'(strm.out_data), 256'(exp));
      check("hold_in_ready", 256'(strm.in_ready), 256'(0));
    end
    strm.out_ready = 1'b1;
    @(negedge clk);
    strm.out_ready = 1'b0;
    check("post_valid", 256'(strm.out_valid), 256'(0));
    check("post_in_ready", 256'(strm.in_ready), 256'(1));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [127:0] got, d;
    int cyc;
    bit seen;

    enc_tab[PT1] = CT_ECB;       dec_tab[CT_ECB] = PT1;
    enc_tab[PT1 ^ IV] = CT1;     dec_tab[CT1] = PT1 ^ IV;
    enc_tab[PT2 ^ CT1] = CT2;    dec_tab[CT2] = PT2 ^ CT1;

    strm.in_valid = 1'b0; strm.in_data = '0; strm.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 256'(strm.in_ready), 256'(0));
    check("rst_out_valid", 256'(strm.out_valid), 256'(0));
    check("rst_flags", 256'({busy, err, core_start}), 256'(0));
    check("rst_out_data", 256'(strm.out_data), 256'(0));
    check("rst_core_in", 256'(core_data_in), 256'(0));
    check("rst_core_key", core_key, 256'(0));
    reset_n = 1'b1;
    #1 check("idle_in_ready", 256'(strm.in_ready), 256'(1));

    // ECB known answer
    load_cfg(1'b0, 1'b0, 2'd0, KEY, '0);
    run_block(PT1, 0, 1'b0, got);
    check("ecb_kat", 256'(got), 256'(CT_ECB));

    // CBC encipher, two blocks
    load_cfg(1'b0, 1'b1, 2'd0, KEY, IV);
    core_lat = 1;
    run_block(PT1, 0, 1'b0, got);
    check("cbc_enc_b1", 256'(got), 256'(CT1));
    core_lat = 5;
    run_block(PT2, 0, 1'b0, got);
    check("cbc_enc_b2", 256'(got), 256'(CT2));

    // CBC decipher, two blocks
    load_cfg(1'b1, 1'b1, 2'd0, KEY, IV);
    core_lat = 2;
    run_block(CT1, 0, 1'b0, got);
    check("cbc_dec_b1", 256'(got), 256'(PT1));
    run_block(CT2, 0, 1'b0, got);
    check("cbc_dec_b2", 256'(got), 256'(PT2));
    check("chain_after_dec", 256'(dut.chain), 256'(CT2));

    // Backpressure with an ignored cfg_load in OUT; following block keeps the old chain
    load_cfg(1'b0, 1'b1, 2'd0, KEY, rnd128());
    run_block(rnd128(), 10, 1'b1, got);
    run_block(rnd128(), 0, 1'b0, got);

    // Timeout mid-message: block dropped, chain untouched, err sticky
    core_hang = 1'b1;
    @(negedge clk);
    strm.in_valid = 1'b1;
    strm.in_data  = rnd128();
    @(posedge clk);
    cyc = 0; seen = 1'b0;
    do begin
      @(negedge clk);
      strm.in_valid = 1'b0;
      cyc++;
      if (strm.out_valid) seen = 1'b1;
    end while (!err && cyc < 100);
    check("timeout_cycles", 256'(cyc), 256'(SC + TO + 1));
    check("timeout_err", 256'(err), 256'(1));
    check("timeout_no_out", 256'(seen), 256'(0));
    check("timeout_idle", 256'({busy, strm.in_ready}), 256'(2'b01));
    core_hang = 1'b0;
    core_lat  = 4;
    run_block(rnd128(), 1, 1'b0, got);
    check("err_sticky", 256'(err), 256'(1));

    // cfg_load and in_valid together in IDLE: cfg wins, block waits
    d = rnd128();
    @(negedge clk);
    cfg_enc_dec = 1'b0; cfg_chain_en = 1'b0; cfg_mode = 2'd2; cfg_key = {rnd128(), rnd128()};
    iv = rnd128();
    cfg_load = 1'b1;
    strm.in_valid = 1'b1;
    strm.in_data  = d;
    #1 check("cfg_prio_ready", 256'(strm.in_ready), 256'(0));
    @(negedge clk);
    cfg_load = 1'b0;
    strm.in_valid = 1'b0;
    check("cfg_prio_idle", 256'(busy), 256'(0));
    check("cfg_prio_err", 256'(err), 256'(0));
    m_dec = 1'b0; m_cbc = 1'b0; m_mode = 2'd2; m_key = cfg_key; m_chain = iv;
    run_block(d, 0, 1'b0, got);

    // Randomized messages against the reference model
    for (int m = 0; m < 8; m++) begin
      load_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               {rnd128(), rnd128()}, rnd128());
      for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
        core_lat = $urandom_range(1, 6);
        run_block(rnd128(), $urandom_range(0, 3), 1'b0, got);
      end
    end

    // Reset during WAIT, then the ECB vector again
    core_lat = 8;
    load_cfg(1'b0, 1'b0, 2'd0, KEY, '0);
    @(negedge clk);
    strm.in_valid = 1'b1;
    strm.in_data  = PT1;
    @(posedge clk);
    repeat (SC + 2) begin @(negedge clk); strm.in_valid = 1'b0; end
    check("pre_reset_busy", 256'(busy), 256'(1));
    reset_n = 1'b0;
    #1;
    check("mid_rst_outs", 256'({core_start, strm.out_valid, busy, strm.in_ready}), 256'(0));
    check("mid_rst_core_in", 256'(core_data_in), 256'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_dec = 1'b0; m_cbc = 1'b0; m_mode = '0; m_key = '0; m_chain = '0;
    repeat (10) @(negedge clk);
    core_lat = 3;
    load_cfg(1'b0, 1'b0, 2'd0, KEY, '0);
    run_block(PT1, 0, 1'b0, got);
    check("ecb_kat_after_rst", 256'(got), 256'(CT_ECB));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_cbc_ctrl.md
Name: aes_cbc_ctrl

Overview:
Streaming front-end that sits directly upstream of aes_core_gen and consumes its results.
- Accepts 128-bit blocks on a valid/ready input stream.
- Applies ECB or CBC chaining and drives the core's start/enc_dec/mode/key/data_in.
- Waits for the core's done, then presents each result block on a valid/ready output stream.
- Holds the chaining register, so multi-block CBC messages run back-to-back without software XORs.

Parameters:
START_CYCLES, 2, number of cycles core_start is held high per block (min 1).
TIMEOUT, 1024, max cycles in WAIT before the block is abandoned with err set.

Ports:
clk  input  1  system clock, all logic rising-edge.
reset_n  input  1  asynchronous active-low reset.
cfg_load  input  1  single-cycle pulse; latches cfg_* and iv; accepted only in IDLE, ignored otherwise.
cfg_enc_dec  input  1  0 = encipher, 1 = decipher (core encoding).
cfg_chain_en  input  1  0 = ECB, 1 = CBC.
cfg_mode  input  2  key-size code passed to core (0 = AES-128).
cfg_key  input  256  key in core format (AES-128 key in bits 255:128, rest zero).
iv  input  128  CBC initial vector.
in_valid  input  1  input block valid.
in_ready  output  1  controller can accept a block.
in_data  input  128  plaintext (enc) or ciphertext (dec).
out_valid  output  1  result block valid.
out_ready  input  1  downstream accepts result.
out_data  output  128  result block.
busy  output  1  high in any state except IDLE.
err  output  1  sticky timeout flag; cleared by cfg_load or reset.
core_start  output  1  to aes_core_gen start.
core_enc_dec  output  1  to core enc_dec (latched cfg).
core_mode  output  2  to core mode (latched cfg).
core_key  output  256  to core key (latched cfg).
core_data_in  output  128  to core data_in; stable from START through WAIT.
core_data_out  input  128  from core data_out.
core_done  input  1  from core done (level).

Behaviour:
- Reset values:
  - All state cleared, FSM = IDLE.
  - in_ready = 0 during reset, then 1 in IDLE.
  - out_valid, busy, err, core_start = 0.
  - out_data, core_data_in, chain register, latched cfg/key = 0.
- FSM states: IDLE, START, WAIT, OUT.
- IDLE:
  - in_ready = 1.
  - cfg_load latches cfg, key and chain <= iv, clears err.
  - If cfg_load and in_valid arrive in the same cycle, cfg_load takes priority and in_ready is forced 0 that cycle.
  - in_valid & in_ready: capture block, go to START.
- Core input formation on capture:
  - enc & CBC: core_data_in = in_data ^ chain.
  - dec & CBC: core_data_in = in_data; in_data is also saved as next_chain.
  - ECB: core_data_in = in_data.
- START:
  - core_start = 1 for exactly START_CYCLES cycles, then 0.
  - Go to WAIT; the timeout counter resets on entry.
- WAIT:
  - core_done is ignored during the first cycle after core_start falls, so a stale done cannot be taken as completion.
  - On core_done = 1, sample core_data_out.
  - out_data and chain update:
    - enc: out_data = core_data_out; chain <= core_data_out.
    - dec CBC: out_data = core_data_out ^ chain; chain <= next_chain.
    - ECB: out_data = core_data_out; chain unchanged.
  - Then go to OUT.
  - If the counter reaches TIMEOUT before done: set err, leave chain unchanged, drop the block (no out_valid), return to IDLE.
- OUT:
  - out_valid = 1; out_data held stable until out_valid & out_ready.
  - On handshake: out_valid = 0 next cycle, return to IDLE.
  - Latency from input handshake to out_valid = START_CYCLES + 1 + core latency + 1 cycles minimum.
- Only one block in flight; in_ready = 0 outside IDLE.
- cfg_load outside IDLE is ignored; cfg, key and chain never change mid-block.
- reset_n low mid-operation:
  - Immediate return to reset values; the in-flight block is lost.
  - core_start drops asynchronously.
- All XORs are full 128-bit; no width extension.

Test Plan:
- ECB encipher: cfg_load (enc, ECB, mode 0, key 2b7e151628aed2a6abf7158809cf4f3c in upper half); in_data 6bc1bee22e409f96e93d7e117393172a -> out_data 3ad77bb40d7a3660a89ecaf32466ef97; core_start high exactly 2 cycles.
- CBC encipher two blocks, iv 000102030405060708090a0b0c0d0e0f, same key:
  - 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d.
  - ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.
- CBC decipher: the two ciphertexts above with the same iv -> the two plaintexts in order; chain equals 5086cb9b507219ee95db113a917678b2 after block 2.
- Backpressure: out_ready low 10 cycles in OUT -> out_valid and out_data stable, in_ready 0; handshake then in_ready 1 next cycle; a new cfg_load in OUT is ignored.
- Timeout: core_done tied 0, TIMEOUT = 16 -> err = 1 after 16 WAIT cycles, no out_valid, back in IDLE; the next cfg_load clears err.
- Reset mid-WAIT: reset_n low -> core_start, out_valid, busy 0 at once; after release, the ECB vector again yields 3ad77bb40d7a3660a89ecaf32466ef97.
